// File: rtl/bomberman_pkg.sv
// Shared types and widths for the bomberman sprite movement controller.
// Optional feature macro used by the controller: BOMBERMAN_RUN_EN.
package bomberman_pkg;

    localparam int COORD_W = 4;
    localparam int PIX_W   = 10;

    typedef enum logic [1:0] {IDLE, REQ, MOVE} state_t;

    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

endpackage

// File: rtl/bomberman_dir_sel.sv
// Button priority (up > down > left > right) plus grid bounds check.
// The target is valid only when the chosen neighbour lies inside the grid.
module bomberman_dir_sel
    import bomberman_pkg::*;
#(
    parameter int COLS = 10,
    parameter int ROWS = 7
) (
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic [COORD_W-1:0] cell_col,
    input  logic [COORD_W-1:0] cell_row,
    output logic               valid,
    output dir_t               dir,
    output logic [COORD_W-1:0] tgt_col,
    output logic [COORD_W-1:0] tgt_row
);

    localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(COLS - 1);
    localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(ROWS - 1);

    // The highest-priority button wins even if its target is off-grid.
    always_comb begin
        valid   = 1'b0;
        dir     = DIR_UP;
        tgt_col = cell_col;
        tgt_row = cell_row;
        if (btn_up) begin
            dir     = DIR_UP;
            valid   = (cell_row != '0);
            tgt_row = cell_row - COORD_W'(1);
        end else if (btn_down) begin
            dir     = DIR_DOWN;
            valid   = (cell_row < LAST_ROW);
            tgt_row = cell_row + COORD_W'(1);
        end else if (btn_left) begin
            dir     = DIR_LEFT;
            valid   = (cell_col != '0);
            tgt_col = cell_col - COORD_W'(1);
        end else if (btn_right) begin
            dir     = DIR_RIGHT;
            valid   = (cell_col < LAST_COL);
            tgt_col = cell_col + COORD_W'(1);
        end
    end

endmodule

// File: rtl/bomberman_move_ctrl.sv
// Frame-paced sprite movement: map query handshake, pixel walk and walk animation.
// Define BOMBERMAN_RUN_EN to add the 'run' input (double-speed steps and animation).
module bomberman_move_ctrl
    import bomberman_pkg::*;
#(
    parameter int CELL        = 64,
    parameter int STEP        = 4,
    parameter int COLS        = 10,
    parameter int ROWS        = 7,
    parameter int START_COL   = 0,
    parameter int START_ROW   = 0,
    parameter int ANIM_FRAMES = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
`ifdef BOMBERMAN_RUN_EN
    input  logic               run,
`endif
    output logic               map_req,
    output logic [COORD_W-1:0] map_col,
    output logic [COORD_W-1:0] map_row,
    input  logic               map_ack,
    input  logic               map_free,
    output logic [PIX_W-1:0]   posx,
    output logic [PIX_W-1:0]   posy,
    output logic               anim_pos,
    output logic               moving,
    output logic [COORD_W-1:0] cell_col,
    output logic [COORD_W-1:0] cell_row
);

    localparam int OFF_W   = $clog2(CELL) + 1;
    localparam int CELL_SH = $clog2(CELL);
    localparam int ANIM_W  = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;

    state_t state, next_state;
    dir_t   dir_q;

    logic [OFF_W-1:0]   offset;
    logic [ANIM_W-1:0]  anim_cnt;

    logic               sel_valid;
    dir_t               sel_dir;
    logic [COORD_W-1:0] sel_col, sel_row;

    logic [OFF_W-1:0]   step_amt;
    logic [OFF_W:0]     off_sum;
    logic               landing;
    logic [PIX_W-1:0]   step_px;
    logic [PIX_W-1:0]   land_x, land_y;
    logic [ANIM_W:0]    anim_inc, anim_sum;
    logic               anim_wrap;

    bomberman_dir_sel #(
        .COLS(COLS),
        .ROWS(ROWS)
    ) u_dir_sel (
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .cell_col  (cell_col),
        .cell_row  (cell_row),
        .valid     (sel_valid),
        .dir       (sel_dir),
        .tgt_col   (sel_col),
        .tgt_row   (sel_row)
    );

`ifdef BOMBERMAN_RUN_EN
    assign step_amt = run ? OFF_W'(2 * STEP) : OFF_W'(STEP);
    assign anim_inc = run ? (ANIM_W+1)'(2) : (ANIM_W+1)'(1);
`else
    assign step_amt = OFF_W'(STEP);
    assign anim_inc = (ANIM_W+1)'(1);
`endif

    // Reaching or overshooting the cell snaps to the cell origin (run saturation).
    assign off_sum   = {1'b0, offset} + {1'b0, step_amt};
    assign landing   = (off_sum >= (OFF_W+1)'(CELL));
    assign step_px   = PIX_W'(step_amt);
    assign land_x    = PIX_W'(map_col) << CELL_SH;
    assign land_y    = PIX_W'(map_row) << CELL_SH;
    assign anim_sum  = {1'b0, anim_cnt} + anim_inc;
    assign anim_wrap = (anim_sum >= (ANIM_W+1)'(ANIM_FRAMES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (frame_tick && sel_valid) next_state = REQ;
            REQ:     if (map_ack) next_state = map_free ? MOVE : IDLE;
            MOVE:    if (frame_tick && landing) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // map_col/map_row keep the target through MOVE and supply the landing cell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            map_req  <= 1'b0;
            map_col  <= '0;
            map_row  <= '0;
            dir_q    <= DIR_UP;
            offset   <= '0;
            anim_cnt <= '0;
            anim_pos <= 1'b0;
            moving   <= 1'b0;
            cell_col <= COORD_W'(START_COL);
            cell_row <= COORD_W'(START_ROW);
            posx     <= PIX_W'(START_COL * CELL);
            posy     <= PIX_W'(START_ROW * CELL);
        end else begin
            moving <= (next_state == MOVE);
            case (state)
                IDLE: begin
                    offset   <= '0;
                    anim_cnt <= '0;
                    anim_pos <= 1'b0;
                    if (frame_tick && sel_valid) begin
                        map_req <= 1'b1;
                        map_col <= sel_col;
                        map_row <= sel_row;
                        dir_q   <= sel_dir;
                    end
                end
                REQ: begin
                    if (map_ack) map_req <= 1'b0;
                end
                MOVE: begin
                    if (frame_tick) begin
                        if (landing) begin
                            posx     <= land_x;
                            posy     <= land_y;
                            cell_col <= map_col;
                            cell_row <= map_row;
                            offset   <= '0;
                            anim_cnt <= '0;
                            anim_pos <= 1'b0;
                        end else begin
                            offset <= off_sum[OFF_W-1:0];
                            case (dir_q)
                                DIR_UP:    posy <= posy - step_px;
                                DIR_DOWN:  posy <= posy + step_px;
                                DIR_LEFT:  posx <= posx - step_px;
                                DIR_RIGHT: posx <= posx + step_px;
                                default:   ;
                            endcase
                            if (anim_wrap) begin
                                anim_cnt <= ANIM_W'(anim_sum - (ANIM_W+1)'(ANIM_FRAMES));
                                anim_pos <= ~anim_pos;
                            end else begin
                                anim_cnt <= anim_sum[ANIM_W-1:0];
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/bomberman_move_ctrl.md
Name: bomberman_move_ctrl

Overview:
- Sequences the position and walk animation of the bomberman sprite renderer.
- Once per frame it samples the direction buttons and asks the level map whether the target cell is free through a req/ack handshake.
- If the cell is free, it walks the sprite pixel by pixel into that cell.
- Drives posx/posy (sprite top-left pixel) and anim_pos (walk-frame select) into the sprite pipeline.

Parameters:
- CELL, 64: cell size in pixels; power of 2.
- STEP, 4: pixels moved per frame; power of 2; must divide CELL.
- COLS, 10: grid columns (0..COLS-1).
- ROWS, 7: grid rows (0..ROWS-1).
- START_COL, 0: reset column.
- START_ROW, 0: reset row.
- ANIM_FRAMES, 8: frames between anim_pos toggles while moving.

Ports:
- clk, in, 1: system clock. Reset is asynchronous and active-low.
- rst_n, in, 1: asynchronous active-low reset.
- frame_tick, in, 1: one-clk pulse per frame (vsync start).
- btn_up, btn_down, btn_left, btn_right, in, 1 each: level-sensitive direction buttons.
- map_req, out, 1: cell query request.
- map_col, out, 4: queried column.
- map_row, out, 4: queried row.
- map_ack, in, 1: map answer valid.
- map_free, in, 1: target cell walkable; sampled only with map_ack.
- posx, out, 10: sprite x pixel.
- posy, out, 10: sprite y pixel.
- anim_pos, out, 1: walk-animation frame select.
- moving, out, 1: high in MOVE.
- cell_col, out, 4: current column.
- cell_row, out, 4: current row.

Behaviour:
- Reset values (async, rst_n low):
  - state=IDLE, map_req=0, map_col/map_row=0, moving=0, anim_pos=0.
  - cell_col=START_COL, cell_row=START_ROW.
  - posx=START_COL*CELL, posy=START_ROW*CELL.
  - Internal offset, direction and animation counter all 0.
  - Reset mid-move or mid-request aborts the operation immediately.
- States IDLE, REQ, MOVE. All outputs are registered.
- IDLE:
  - On frame_tick, select a direction by priority up > down > left > right.
  - If no button is pressed, or the target cell is outside 0..COLS-1 / 0..ROWS-1: stay in IDLE, no request.
  - Otherwise latch the direction and go to REQ. Next cycle: map_req=1, map_col/map_row = target cell.
- REQ:
  - map_req and the address are held stable until map_ack.
  - map_ack with map_free=1: go to MOVE next cycle.
  - map_ack with map_free=0: return to IDLE.
  - map_req drops the cycle after ack.
  - frame_tick during REQ is ignored; it does not count as a movement step.
  - map_ack while not in REQ is ignored.
  - map_ack is permitted in the first cycle map_req is high.
- MOVE:
  - On each frame_tick: offset += STEP, and posx/posy move STEP pixels in the latched direction. Register updates the cycle after the tick.
  - When offset reaches CELL: posx/posy land exactly on the cell origin, cell_col/cell_row update, offset clears, go to IDLE.
  - Buttons are ignored in MOVE; releasing mid-move still completes the move.
  - A new move can start at the first frame_tick after returning to IDLE.
- Arithmetic:
  - posx/posy are 10-bit unsigned; range is guaranteed by the grid bounds, so no overflow handling.
  - offset width is log2(CELL)+1.
- Animation:
  - Frame counter increments on frame_tick while in MOVE.
  - At ANIM_FRAMES-1 the counter wraps and anim_pos toggles.
  - In IDLE the counter and anim_pos are forced to 0 (standing pose).
- moving = (state==MOVE).

Optional Feature:
- Macro: BOMBERMAN_RUN_EN.
- Defined:
  - Adds input port `run` (1 bit), sampled at each frame_tick in MOVE.
  - run=1 steps 2*STEP pixels per tick, saturating so the sprite lands exactly at CELL.
  - run=1 also advances the animation counter by 2 per tick.
- Undefined: no `run` port; the step is always STEP.

Decomposition:
- Package bomberman_pkg holds:
  - enum state_t {IDLE, REQ, MOVE}
  - enum dir_t {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT}
  - localparam widths for cell coordinates (4) and pixels (10).
- One sub-module, bomberman_dir_sel: combinational button priority plus bounds check; outputs valid, dir, target col/row.
- FSM, position registers and animation counter stay in the top module.

Test Plan:
- Reset with START_COL=2, START_ROW=1 → posx=128, posy=64, anim_pos=0, map_req=0.
- Hold btn_right, frame_tick, ack free after 3 cycles → map_req held 3 cycles with map_col=3, map_row=1; after 16 ticks posx=192, cell_col=3, moving falls.
- btn_left at col 0 plus frame_tick → map_req never rises, state stays IDLE.
- btn_up with map_ack & map_free=0 → back to IDLE, posy unchanged.
- btn_up+btn_right together → map_row=row-1, map_col unchanged (up wins). frame_tick during REQ → posx/posy unchanged.
- rst_n low at tick 5 of a move → posx/posy return to start immediately; anim_pos toggles every 8 ticks in a normal move.
